// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI write-only register bank receiver.
// Frame layout is MSB first: rw, addr, data.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 8;
  localparam int FRAME_W    = 1 + DEF_ADDR_W + DEF_DATA_W;
  localparam int CNT_W      = $clog2(FRAME_W + 2);

  function automatic int frame_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  function automatic int reg_lsb(input int k, input int data_w);
    return k * data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with a trailing delay flop
// so the synced level can be compared against its previous value for edges.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              delay_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= {STAGES{RST_VAL}};
      delay_reg <= RST_VAL;
    end else begin
      sync_reg  <= {sync_reg[STAGES-2:0], din};
      delay_reg <= sync_reg[STAGES-1];
    end
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = sync_reg[STAGES-1] & ~delay_reg;
  assign fall  = ~sync_reg[STAGES-1] & delay_reg;

endmodule

// File: rtl/spi_reg_bank_rx.sv
// SPI mode-0 write-only receiver: synchronises the pins, assembles {rw, addr, data}
// frames and writes them into a register bank with per-register strobes and error pulses.
module spi_reg_bank_rx
  import spi_reg_pkg::*;
#(
  parameter int                NUM_REGS    = 5,
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 7,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         spi_sclk,
  input  logic                         spi_cs_n,
  input  logic                         spi_copi,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         err_frame,
  output logic                         err_addr
);

  localparam int              FW           = frame_width(ADDR_W, DATA_W);
  localparam int              CW           = $clog2(FW + 2);
  localparam logic [CW-1:0]   CNT_FULL     = CW'(FW);
  localparam logic [CW-1:0]   CNT_SAT      = CW'(FW + 1);
  localparam logic [ADDR_W:0] NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);

  logic sclk_level_unused, sclk_rise, sclk_fall_unused;
  logic cs_level, cs_rise, cs_fall;
  logic copi_level, copi_rise_unused, copi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spi_sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall_unused)
  );

  // cs_n chain resets low so a frame already in flight at reset release never shows a fall.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spi_cs_n),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spi_copi),
    .level (copi_level),
    .rise  (copi_rise_unused),
    .fall  (copi_fall_unused)
  );

  state_t            state_reg;
  logic [FW-1:0]     shift_reg;
  logic [CW-1:0]     count_reg;
  logic              err_frame_reg;
  logic              err_addr_reg;
  logic [NUM_REGS-1:0] wr_strobe_reg;
  logic [NUM_REGS-1:0] wr_sel;
  logic [DATA_W-1:0] bank_reg [NUM_REGS];

  logic              frame_rw;
  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;
  logic              in_commit;
  logic              addr_ok;
  logic              write_ok;

  assign frame_rw   = shift_reg[FW-1];
  assign frame_addr = shift_reg[FW-2 -: ADDR_W];
  assign frame_data = shift_reg[DATA_W-1:0];
  assign in_commit  = (state_reg == COMMIT);
  assign addr_ok    = ({1'b0, frame_addr} < NUM_REGS_EXT);
  assign write_ok   = in_commit & frame_rw & addr_ok;

  // A cs_n rise takes priority over an sclk rise seen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      count_reg     <= '0;
      err_frame_reg <= 1'b0;
    end else begin
      err_frame_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cs_fall) begin
            state_reg <= SHIFT;
            shift_reg <= '0;
            count_reg <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            if (count_reg == CNT_FULL) begin
              state_reg <= COMMIT;
            end else begin
              state_reg     <= IDLE;
              err_frame_reg <= 1'b1;
            end
          end else if (sclk_rise && !cs_level) begin
            shift_reg <= {shift_reg[FW-2:0], copi_level};
            if (count_reg != CNT_SAT) begin
              count_reg <= count_reg + CW'(1);
            end
          end
        end
        COMMIT: begin
          if (cs_fall) begin
            state_reg <= SHIFT;
            shift_reg <= '0;
            count_reg <= '0;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bank
      assign wr_sel[gi] = write_ok && (frame_addr == ADDR_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bank_reg[gi] <= RESET_VAL;
        end else if (wr_sel[gi]) begin
          bank_reg[gi] <= frame_data;
        end
      end

      assign regs_out[reg_lsb(gi, DATA_W) +: DATA_W] = bank_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_strobe_reg <= '0;
      err_addr_reg  <= 1'b0;
    end else begin
      wr_strobe_reg <= wr_sel;
      err_addr_reg  <= in_commit & frame_rw & ~addr_ok;
    end
  end

  assign wr_strobe = wr_strobe_reg;
  assign err_frame = err_frame_reg;
  assign err_addr  = err_addr_reg;

endmodule

// File: tb/tb_spi_reg_bank_rx.sv
// Randomised bench for spi_reg_bank_rx: drives SPI mode-0 frames at clk/4 with random
// phase and compares writes, errors and the bank against a frame-level reference model.
module tb_spi_reg_bank_rx;
  import spi_reg_pkg::*;

  localparam int NUM_REGS = 5;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;
  localparam int SYNC     = 2;
  localparam int FLEN     = FRAME_W;
  localparam int CLK_P    = 10;
  localparam int HALF     = 2 * CLK_P;

  logic                       clk;
  logic                       rst_n;
  logic                       spi_sclk;
  logic                       spi_cs_n;
  logic                       spi_copi;
  logic [NUM_REGS*DATA_W-1:0] regs_out;
  logic [NUM_REGS-1:0]        wr_strobe;
  logic                       err_frame;
  logic                       err_addr;

  spi_reg_bank_rx #(
    .NUM_REGS    (NUM_REGS),
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (SYNC),
    .RESET_VAL   (8'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_copi  (spi_copi),
    .regs_out  (regs_out),
    .wr_strobe (wr_strobe),
    .err_frame (err_frame),
    .err_addr  (err_addr)
  );

  initial clk = 1'b0;
  always #(CLK_P/2) clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  logic [DATA_W-1:0] model_regs [NUM_REGS];
  int exp_addr_q[$];
  int exp_data_q[$];
  int exp_err_frame = 0;
  int exp_err_addr  = 0;

  // observations
  int obs_addr_q[$];
  int obs_data_q[$];
  int obs_err_frame = 0;
  int obs_err_addr  = 0;
  int excl_viol     = 0;
  int lat_viol      = 0;
  longint t_cs_rise = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    int hits;
    if (rst_n) begin
      hits = $countones(wr_strobe) + int'(err_frame) + int'(err_addr);
      if (hits > 1) excl_viol++;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_strobe[k]) begin
          obs_addr_q.push_back(k);
          obs_data_q.push_back(int'(regs_out[k*DATA_W +: DATA_W]));
          if (($time - t_cs_rise + CLK_P - 1) / CLK_P > SYNC + 4) lat_viol++;
        end
      end
      if (err_frame) obs_err_frame++;
      if (err_addr)  obs_err_addr++;
    end
  end

  // Frame-level rules: wrong length -> framing error; read -> ignored;
  // write to a missing register -> address error; otherwise the register takes the data.
  task automatic model_frame(input logic [31:0] val, input int nbits);
    int rw, addr, data;
    if (nbits != FLEN) begin
      exp_err_frame++;
    end else begin
      rw   = int'(val[FLEN-1]);
      addr = int'(val[FLEN-2 -: ADDR_W]);
      data = int'(val[DATA_W-1:0]);
      if (rw == 1) begin
        if (addr < NUM_REGS) begin
          model_regs[addr] = DATA_W'(data);
          exp_addr_q.push_back(addr);
          exp_data_q.push_back(data);
        end else begin
          exp_err_addr++;
        end
      end
    end
  endtask

  task automatic cs_low();
    #($urandom_range(0, CLK_P - 1));
    spi_cs_n = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] val, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_copi = val[i];
      #HALF;
      spi_sclk = 1'b1;
      #HALF;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_high();
    #HALF;
    spi_cs_n  = 1'b1;
    t_cs_rise = $time;
  endtask

  task automatic send_frame(input logic [31:0] val, input int nbits);
    $display("[TB] frame bits=%0d val=%0h", nbits, val);
    model_frame(val, nbits);
    cs_low();
    #HALF;
    send_bits(val, nbits);
    cs_high();
  endtask

  task automatic check_bank(input string tag);
    logic [NUM_REGS*DATA_W-1:0] exp_vec;
    for (int k = 0; k < NUM_REGS; k++) exp_vec[k*DATA_W +: DATA_W] = model_regs[k];
    check_eq({tag, "/regs"}, 64'(regs_out), 64'(exp_vec));
  endtask

  task automatic settle_check(input string tag);
    int oa, od, ea, ed;
    repeat (12) @(posedge clk);
    #1;
    check_eq({tag, "/err_frame"}, 64'(obs_err_frame), 64'(exp_err_frame));
    check_eq({tag, "/err_addr"}, 64'(obs_err_addr), 64'(exp_err_addr));
    check_eq({tag, "/n_writes"}, 64'(obs_addr_q.size()), 64'(exp_addr_q.size()));
    while (obs_addr_q.size() > 0 && exp_addr_q.size() > 0) begin
      oa = obs_addr_q.pop_front(); od = obs_data_q.pop_front();
      ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
      check_eq({tag, "/wr_addr"}, 64'(oa), 64'(ea));
      check_eq({tag, "/wr_data"}, 64'(od), 64'(ed));
    end
    check_bank(tag);
    obs_addr_q.delete(); obs_data_q.delete();
    exp_addr_q.delete(); exp_data_q.delete();
    obs_err_frame = 0; obs_err_addr = 0;
    exp_err_frame = 0; exp_err_addr = 0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_REGS; k++) model_regs[k] = '0;
  endtask

  initial begin
    logic [31:0] val;
    int nbits, pick, addr;

    rst_n = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_copi = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset/regs", 64'(regs_out), 64'(0));
    check_eq("reset/strobe", 64'(wr_strobe), 64'(0));
    check_eq("reset/errs", 64'({err_frame, err_addr}), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);

    send_frame(32'h80A5, FLEN);
    settle_check("t1_w_addr0");

    send_frame(32'h8433, FLEN);
    #((SYNC + 3) * CLK_P);
    send_frame(32'h84F0, FLEN);
    settle_check("t2_back2back");

    send_frame(32'h9077, FLEN);
    settle_check("t3_bad_addr");

    send_frame(32'h4052, FLEN - 1);
    #(8 * CLK_P);
    send_frame(32'h1_80A5, FLEN + 1);
    settle_check("t4_bad_len");

    send_frame(32'h0155, FLEN);
    settle_check("t5_read");

    // Reset mid-frame with cs_n held low; the rest of that frame must be ignored.
    $display("[TB] frame bits=8 val=81 then reset");
    cs_low();
    #HALF;
    send_bits(32'h81, 8);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("t6_reset/regs_now", 64'(regs_out), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    send_bits(32'h22, 8);
    cs_high();
    settle_check("t6_after_reset");
    repeat (4) @(posedge clk);
    send_frame(32'h8122, FLEN);
    settle_check("t6_next_frame");

    for (int n = 0; n < 40; n++) begin
      pick = int'($urandom_range(0, 9));
      case (pick)
        0: nbits = FLEN - 1;
        1: nbits = FLEN + 1 + int'($urandom_range(0, 2));
        2: nbits = int'($urandom_range(0, 8));
        default: nbits = FLEN;
      endcase
      addr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127))
                                         : int'($urandom_range(0, NUM_REGS + 1));
      val = '0;
      val[FLEN-1]          = ($urandom_range(0, 3) != 0);
      val[FLEN-2 -: ADDR_W] = ADDR_W'(addr);
      val[DATA_W-1:0]      = DATA_W'($urandom);
      if (nbits > FLEN) val[nbits-1 -: 3] = 3'($urandom);
      send_frame(val, nbits);
      #(int'($urandom_range(SYNC + 3, SYNC + 8)) * CLK_P);
      if ((n % 4) == 3) settle_check("rand");
    end
    settle_check("rand_final");

    check_eq("exclusive_outputs", 64'(excl_viol), 64'(0));
    check_eq("write_latency", 64'(lat_viol), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
